costas_tick_scheduler: RTL
==========================

# costas_tick_scheduler

Programmable loop-rate scheduler for the Costas receiver. It divides the system clock by a run-time configurable ratio and, on every divided tick, sequences the three loop-update strobes in a fixed order: phase-detector sample, loop-filter update, NCO update. It replaces fixed divide-by-1001 tick generation with a reconfigurable, glitch-free rate. It also flags ticks that arrive before the previous update sequence has finished.

## Interface
- CNT_W, 10, width of divider counter and divide value
- DEFAULT_DIV, 1000, active_div after reset (tick period = active_div+1 cycles)
- MIN_DIV, 3, smallest accepted divide value; lower requests clamp to MIN_DIV

- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- enable  in  1  counter runs when high; freezes when low
- cfg_valid  in  1  new divide value offered
- cfg_div  in  CNT_W  requested divide value
- cfg_ready  out  1  high when no config is pending; handshake completes on cfg_valid&&cfg_ready
- filter_ready  in  1  loop filter can accept an update
- overrun_clr  in  1  clears sticky overrun
- tick  out  1  one-cycle pulse per divided period
- sample_stb  out  1  phase-detector sample strobe
- filter_stb  out  1  loop-filter update strobe
- nco_stb  out  1  NCO update strobe
- active_div  out  CNT_W  divide value currently in use
- overrun  out  1  sticky: a tick arrived while a sequence was active

## Operation
- Counter: when enable=1, count increments each cycle; at count==active_div it wraps to 0. Every wrap is a "wrap event". When enable=0, count holds and no wrap occurs.
- tick is registered and is high for exactly the cycle after each wrap edge.
- Config: on cfg_valid&&cfg_ready, capture pending=max(cfg_div,MIN_DIV) and set the pending flag. cfg_ready = !pending flag.
  - At the next wrap event, active_div<=pending and the flag clears.
  - The compare on the wrapping edge uses the old active_div.
  - A config is never applied mid-period.
- Sequencer FSM states: IDLE, SAMPLE, FILTER, NCO.
  - IDLE -> SAMPLE on a wrap event.
  - SAMPLE -> FILTER unconditionally.
  - FILTER -> NCO when filter_ready=1; otherwise FILTER holds.
  - NCO -> IDLE.
- Strobes are decoded from the state register:
  - sample_stb = (state==SAMPLE)
  - filter_stb = (state==FILTER && filter_ready)
  - nco_stb = (state==NCO)
- Overrun: a wrap event while state!=IDLE sets overrun.
  - That tick still pulses, but its sequence is dropped.
  - The in-flight sequence continues undisturbed.
- overrun_clr clears overrun. If set and clear occur in the same cycle, set wins.
- The FSM is not gated by enable: a sequence in progress completes while enable=0.

## Timing
- Reset values:
  - count=0, state=IDLE, active_div=DEFAULT_DIV, pending flag=0.
  - tick, sample_stb, filter_stb, nco_stb and overrun are all 0; cfg_ready=1.
- Reset mid-sequence: state returns to IDLE on the reset edge, and any pending config is discarded.
- First tick: number rising edges from reset deassertion (with enable=1) starting at 1.
  - count==k after edge k. The wrap occurs at edge active_div+1.
  - tick and sample_stb are high in the same cycle, immediately after that edge.
- Steady-state tick period is active_div+1 cycles.
- filter_stb follows sample_stb by 1 cycle, plus any cycles with filter_ready low.
- nco_stb follows filter_stb by 1 cycle.
- Minimum sequence length is 3 cycles; MIN_DIV=3 therefore guarantees no overrun while filter_ready is held high.
- cfg_ready drops the cycle after the handshake and rises the cycle after the applying wrap edge. The first period at the new rate starts at that wrap.

## Test plan
- Reset, enable=1, filter_ready=1, no config:
  - tick after edges 1001, 2002, 3003.
  - sample/filter/nco strobes in consecutive cycles starting with the tick cycle.
  - overrun stays 0.
- Config cfg_div=9 accepted mid-period:
  - cfg_ready low until the next wrap.
  - Current period still 1001 cycles; subsequent ticks every 10 cycles.
  - active_div reads 9 after the wrap.
- cfg_div=1 -> active_div becomes 3 (clamped); tick period 4, no overrun with filter_ready=1.
- active_div=3, filter_ready held low 6 cycles after a sample_stb:
  - FILTER holds and the next wrap sets overrun.
  - No second sample_stb occurs until the sequence completes.
  - overrun_clr pulse clears it; clr coincident with a new overrun leaves overrun=1.
- enable low for 50 cycles mid-period: count freezes; the tick is delayed by exactly 50 cycles, and an active sequence still finishes.
- Assert reset while in FILTER with a pending config:
  - Next cycle: state IDLE, all strobes 0, cfg_ready=1, active_div=1000.
  - First tick after reset release follows the DEFAULT_DIV timing.

Source files
------------

// File: rtl/costas_tick_scheduler.sv
// Purpose: programmable loop-rate divider that sequences sample -> filter -> NCO strobes on every divided tick.
// Latency: tick and sample_stb one cycle after the wrap edge; filter_stb follows 1 cycle later (plus stalls), nco_stb 1 after that.
// Backpressure: filter_ready low holds the sequencer in FILTER; cfg_ready stays low while a divide value waits for the next wrap.
module costas_tick_scheduler #(
   parameter int CNT_W       = 10,
   parameter int DEFAULT_DIV = 1000,
   parameter int MIN_DIV     = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   input  logic             filter_ready,
   input  logic             overrun_clr,
   output logic             tick,
   output logic             sample_stb,
   output logic             filter_stb,
   output logic             nco_stb,
   output logic [CNT_W-1:0] active_div,
   output logic             overrun
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      FILTER = 2'd2,
      NCO    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] pend_div;
   logic             pend_vld;
   state_t           state;
   logic             wrap;
   logic             cfg_fire;
   logic [CNT_W-1:0] cfg_clamped;

   // A wrap only happens on a counting cycle; the compare always uses the divide value of the running period.
   assign wrap        = enable && (count == active_div);
   assign cfg_fire    = cfg_valid && !pend_vld;
   assign cfg_ready   = !pend_vld;
   assign cfg_clamped = (cfg_div < MIN_DIV_V) ? MIN_DIV_V : cfg_div;

   // Divider counter: freezes while enable is low, returns to 0 on the wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         count <= wrap ? '0 : count + CNT_W'(1);
      end
   end

   // tick is the registered wrap, so it is high exactly one cycle after the wrap edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         tick <= 1'b0;
      end else begin
         tick <= wrap;
      end
   end

   // Config holding register: a new rate is only swapped in at a period boundary, never mid-period.
   always_ff @(posedge clock) begin
      if (reset) begin
         active_div <= DEF_DIV_V;
         pend_div   <= DEF_DIV_V;
         pend_vld   <= 1'b0;
      end else begin
         if (wrap && pend_vld) begin
            active_div <= pend_div;
            pend_vld   <= 1'b0;
         end else if (cfg_fire) begin
            pend_div   <= cfg_clamped;
            pend_vld   <= 1'b1;
         end
      end
   end

   // Update sequencer and sticky overrun; runs regardless of enable so an in-flight sequence always completes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         overrun <= 1'b0;
      end else begin
         // A tick that lands on a busy sequencer is dropped but recorded; a new set beats a coincident clear.
         if (wrap && (state != IDLE)) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE:    if (wrap) state <= SAMPLE;
            SAMPLE:  state <= FILTER;
            FILTER:  if (filter_ready) state <= NCO;
            NCO:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign sample_stb = (state == SAMPLE);
   assign filter_stb = (state == FILTER) && filter_ready;
   assign nco_stb    = (state == NCO);

endmodule
